// File: rtl/common_valid_to_ready_fifo_if.sv
// Write/read handshake bundle for common_valid_to_ready_fifo.
// The slave modport is the FIFO side; master is the producer/consumer side.
interface common_valid_to_ready_fifo_if #(
  parameter int NB_DATA = 8,
  parameter int DEPTH   = 8
);
  localparam int NB_COUNT = $clog2(DEPTH + 1);

  logic [NB_DATA-1:0]  i_data_in;
  logic                i_valid;
  logic [NB_DATA-1:0]  o_data_out;
  logic                o_valid;
  logic                i_ready;
  logic [NB_COUNT-1:0] o_count;
  logic                o_almost_full;
  logic                o_overflow;
  logic                i_clear_ovf;

  modport master (
    output i_data_in, i_valid, i_ready, i_clear_ovf,
    input  o_data_out, o_valid, o_count, o_almost_full, o_overflow
  );

  modport slave (
    input  i_data_in, i_valid, i_ready, i_clear_ovf,
    output o_data_out, o_valid, o_count, o_almost_full, o_overflow
  );
endinterface

// File: rtl/common_valid_to_ready_fifo.sv
// First-word-fall-through FIFO; push-to-output latency 1 cycle, status outputs are flop-only.
// No upstream backpressure: writes to a full queue without a pop are dropped;
// COMMON_FIFO_OVF_FLAG_EN adds the sticky o_overflow flag (tied 0 otherwise).
module common_valid_to_ready_fifo #(
  parameter int NB_DATA        = 8,
  parameter int DEPTH          = 8,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  common_valid_to_ready_fifo_if.slave   bus
);
  localparam int NB_PTR   = $clog2(DEPTH);
  localparam int NB_COUNT = $clog2(DEPTH + 1);

  logic [NB_DATA-1:0]  mem_q [DEPTH];
  logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                push;
  logic                pop;

  always_comb begin
    pop      = (count_q != '0) && bus.i_ready;
    // A full queue still accepts a write when the head leaves on the same edge.
    push     = bus.i_valid && ((count_q != NB_COUNT'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + NB_PTR'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + NB_PTR'(1);
    if (push && !pop)      count_d = count_q + NB_COUNT'(1);
    else if (pop && !push) count_d = count_q - NB_COUNT'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data_in;
  end

  assign bus.o_data_out    = mem_q[rd_ptr_q];
  assign bus.o_valid       = (count_q != '0);
  assign bus.o_count       = count_q;
  assign bus.o_almost_full = (count_q >= NB_COUNT'(ALMOST_FULL_TH));

`ifdef COMMON_FIFO_OVF_FLAG_EN
  logic drop;
  logic ovf_q, ovf_d;

  always_comb begin
    drop  = bus.i_valid && !push;
    ovf_d = ovf_q;
    if (drop)                 ovf_d = 1'b1;
    else if (bus.i_clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  assign bus.o_overflow = ovf_q;
`else
  logic unused_clear_ovf;
  assign unused_clear_ovf = bus.i_clear_ovf;
  assign bus.o_overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_common_valid_to_ready_fifo.sv
// Directed bench for common_valid_to_ready_fifo (DEPTH=8, almost-full at 6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_common_valid_to_ready_fifo;
  localparam int NB = 8;
  localparam int D  = 8;
  localparam int TH = 6;
  localparam int CW = 4;
`ifdef COMMON_FIFO_OVF_FLAG_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct {
    logic          v;
    logic [NB-1:0] d;
    logic          r;
    logic          clr;
    logic          e_valid;
    logic [NB-1:0] e_data;
    logic [CW-1:0] e_count;
    logic          e_af;
    logic          e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  vec_t vecs[$];
  logic [NB-1:0] exp_q[$];

  always #5 clk = ~clk;

  common_valid_to_ready_fifo_if #(.NB_DATA(NB), .DEPTH(D)) bus ();

  common_valid_to_ready_fifo #(.NB_DATA(NB), .DEPTH(D), .ALMOST_FULL_TH(TH)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic v, input logic [NB-1:0] d, input logic r, input logic clr,
                     input logic ev, input logic [NB-1:0] ed, input logic [CW-1:0] ec,
                     input logic eaf, input logic eovf);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.clr = clr;
    x.e_valid = ev; x.e_data = ed; x.e_count = ec; x.e_af = eaf; x.e_ovf = eovf;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic v, input logic [NB-1:0] d, input logic r, input logic clr);
    bus.i_valid     = v;
    bus.i_data_in   = d;
    bus.i_ready     = r;
    bus.i_clear_ovf = clr;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // Basic FWFT fill / hold / drain, then ready-on-empty.
    add(1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 0);
    add(1, 8'h22, 0, 0,  1, 8'h11, 2, 0, 0);
    add(1, 8'h33, 0, 0,  1, 8'h11, 3, 0, 0);
    add(0, 8'h00, 0, 0,  1, 8'h11, 3, 0, 0);
    add(0, 8'h00, 1, 0,  1, 8'h22, 2, 0, 0);
    add(0, 8'h00, 1, 0,  1, 8'h33, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    // Fill to full, then a ninth write that must be dropped.
    for (int i = 0; i < 8; i++)
      add(1, 8'(8'h40 + i), 0, 0, 1, 8'h40, CW'(i + 1), (i + 1) >= TH, 0);
    add(1, 8'h48, 0, 0,  1, 8'h40, 8, 1, OVF);
    // Clear coinciding with another drop: set wins; then clear alone.
    add(1, 8'h50, 0, 1,  1, 8'h40, 8, 1, OVF);
    add(0, 8'h00, 0, 1,  1, 8'h40, 8, 1, 0);

    @(negedge clk);
    @(negedge clk);
    check("reset_valid", 32'(bus.o_valid), 0);
    check("reset_count", 32'(bus.o_count), 0);
    check("reset_af",    32'(bus.o_almost_full), 0);
    check("reset_ovf",   32'(bus.o_overflow), 0);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].v, vecs[k].d, vecs[k].r, vecs[k].clr);
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), 32'(bus.o_valid), 32'(vecs[k].e_valid));
      if (vecs[k].e_valid)
        check($sformatf("vec%0d_data", k), 32'(bus.o_data_out), 32'(vecs[k].e_data));
      check($sformatf("vec%0d_count", k), 32'(bus.o_count), 32'(vecs[k].e_count));
      check($sformatf("vec%0d_af", k), 32'(bus.o_almost_full), 32'(vecs[k].e_af));
      check($sformatf("vec%0d_ovf", k), 32'(bus.o_overflow), 32'(vecs[k].e_ovf));
    end

    // Full queue streaming across several pointer wraps.
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stream%0d_data", i), 32'(bus.o_data_out), 32'(exp_q[0]));
      check($sformatf("stream%0d_count", i), 32'(bus.o_count), 8);
      drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      exp_q.push_back(8'(8'h60 + i));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    check("stream_end_count", 32'(bus.o_count), 8);
    check("stream_end_ovf", 32'(bus.o_overflow), 0);

    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_data", i), 32'(bus.o_data_out), 32'(exp_q[0]));
      check($sformatf("drain%0d_count", i), 32'(bus.o_count), 32'(8 - i));
      check($sformatf("drain%0d_af", i), 32'(bus.o_almost_full), 32'((8 - i) >= TH));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    check("drain_end_valid", 32'(bus.o_valid), 0);
    check("drain_end_count", 32'(bus.o_count), 0);

    // Asynchronous reset mid-stream with four words queued.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      @(negedge clk);
    end
    check("pre_rst_count", 32'(bus.o_count), 4);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.o_valid), 0);
    check("async_rst_count", 32'(bus.o_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 32'(bus.o_valid), 1);
    check("post_rst_data", 32'(bus.o_data_out), 32'h A5);
    check("post_rst_count", 32'(bus.o_count), 1);

    // Simultaneous push and pop at count 1.
    drive(1'b1, 8'hB6, 1'b1, 1'b0);
    @(negedge clk);
    check("pp1_count", 32'(bus.o_count), 1);
    check("pp1_data", 32'(bus.o_data_out), 32'h B6);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("final_valid", 32'(bus.o_valid), 0);
    check("final_count", 32'(bus.o_count), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
